// File: rtl/regfile_wr_arbiter_if.sv
// Write-port request/grant bundle between the MiniRISC requesters and the register file.
// The master side is the requesters plus the register file; the arbiter is the slave.
interface regfile_wr_arbiter_if;
  logic       ld_req;
  logic [3:0] ld_addr;
  logic [7:0] ld_data;
  logic       ld_gnt;

  logic       alu_req;
  logic [3:0] alu_addr;
  logic [7:0] alu_data;
  logic       alu_gnt;

  logic       sp_req;
  logic       sp_push;
  logic       sp_gnt;
  logic [7:0] sp_in;

  logic [3:0] rf_addr_x;
  logic [7:0] rf_wr_data_x;
  logic       rf_write_en;
  logic       sp_err;

  modport master (
    output ld_req, ld_addr, ld_data,
    output alu_req, alu_addr, alu_data,
    output sp_req, sp_push, sp_in,
    input  ld_gnt, alu_gnt, sp_gnt,
    input  rf_addr_x, rf_wr_data_x, rf_write_en, sp_err
  );

  modport slave (
    input  ld_req, ld_addr, ld_data,
    input  alu_req, alu_addr, alu_data,
    input  sp_req, sp_push, sp_in,
    output ld_gnt, alu_gnt, sp_gnt,
    output rf_addr_x, rf_wr_data_x, rf_write_en, sp_err
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Single-write-port arbiter and SP sequencer for the MiniRISC 16x8 register file.
// Define STACK_LIMIT_CHECK_EN to trap SP over/underflow instead of wrapping.
module regfile_wr_arbiter #(
  parameter logic [3:0]  SP_ADDR      = 4'hF,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  regfile_wr_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_LD,
    SRC_ALU,
    SRC_SP
  } src_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] ld_wait_q,  ld_wait_d;
  logic [3:0] alu_wait_q, alu_wait_d;
  logic [3:0] sp_wait_q,  sp_wait_d;
  logic [3:0] addr_q,     addr_d;
  logic [7:0] data_q,     data_d;
  logic       wen_q,      wen_d;

  logic       sp_hazard;
  logic       sp_ok;
  logic       ld_starved, alu_starved, sp_starved;
  logic [7:0] sp_next;
  src_e       sel;

  // A pending write to SP_ADDR means sp_in is stale until the file commits it.
  assign sp_hazard   = wen_q && (addr_q == SP_ADDR);
  assign sp_ok       = bus.sp_req && !sp_hazard;
  assign ld_starved  = ld_wait_q  >= LIMIT;
  assign alu_starved = alu_wait_q >= LIMIT;
  assign sp_starved  = sp_wait_q  >= LIMIT;
  assign sp_next     = bus.sp_push ? (bus.sp_in - 8'd1) : (bus.sp_in + 8'd1);

  always_comb begin
    sel = SRC_NONE;
    if (!rst_n) begin
      sel = SRC_NONE;
    end else if (sp_ok && sp_starved) begin
      sel = SRC_SP;
    end else if (bus.alu_req && alu_starved) begin
      sel = SRC_ALU;
    end else if (bus.ld_req && ld_starved) begin
      sel = SRC_LD;
    end else if (bus.ld_req) begin
      sel = SRC_LD;
    end else if (bus.alu_req) begin
      sel = SRC_ALU;
    end else if (sp_ok) begin
      sel = SRC_SP;
    end
  end

  assign bus.ld_gnt  = (sel == SRC_LD);
  assign bus.alu_gnt = (sel == SRC_ALU);
  assign bus.sp_gnt  = (sel == SRC_SP);

  function automatic logic [3:0] age(input logic req, input logic gnt, input logic [3:0] q);
    if (req && !gnt) begin
      return (q == 4'hF) ? q : q + 4'd1;
    end
    return '0;
  endfunction

  always_comb begin
    ld_wait_d  = age(bus.ld_req,  bus.ld_gnt,  ld_wait_q);
    alu_wait_d = age(bus.alu_req, bus.alu_gnt, alu_wait_q);
    sp_wait_d  = age(bus.sp_req,  bus.sp_gnt,  sp_wait_q);
  end

`ifdef STACK_LIMIT_CHECK_EN
  logic err_q, err_d;
  logic sp_at_limit;

  assign sp_at_limit = bus.sp_push ? (bus.sp_in == 8'h00) : (bus.sp_in == 8'hFF);
`endif

  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    wen_d  = 1'b0;
`ifdef STACK_LIMIT_CHECK_EN
    err_d  = 1'b0;
`endif
    case (sel)
      SRC_LD: begin
        addr_d = bus.ld_addr;
        data_d = bus.ld_data;
        wen_d  = 1'b1;
      end
      SRC_ALU: begin
        addr_d = bus.alu_addr;
        data_d = bus.alu_data;
        wen_d  = 1'b1;
      end
      SRC_SP: begin
`ifdef STACK_LIMIT_CHECK_EN
        // Limit hit: request is consumed but nothing is written, so no hazard follows.
        if (sp_at_limit) begin
          err_d = 1'b1;
        end else begin
          addr_d = SP_ADDR;
          data_d = sp_next;
          wen_d  = 1'b1;
        end
`else
        addr_d = SP_ADDR;
        data_d = sp_next;
        wen_d  = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_wait_q  <= '0;
      alu_wait_q <= '0;
      sp_wait_q  <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      wen_q      <= 1'b0;
    end else begin
      ld_wait_q  <= ld_wait_d;
      alu_wait_q <= alu_wait_d;
      sp_wait_q  <= sp_wait_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      wen_q      <= wen_d;
    end
  end

`ifdef STACK_LIMIT_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.sp_err = err_q;
`else
  assign bus.sp_err = 1'b0;
`endif

  assign bus.rf_addr_x    = addr_q;
  assign bus.rf_wr_data_x = data_q;
  assign bus.rf_write_en  = wen_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: priority, starvation, SP sequencing, hazard, limits, reset.
module tb_regfile_wr_arbiter;

  logic clk;
  logic rst_n;
  int unsigned n_checks;
  int unsigned n_errors;

  regfile_wr_arbiter_if bus ();

  regfile_wr_arbiter #(
    .SP_ADDR      (4'hF),
    .STARVE_LIMIT (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.ld_req  = 1'b0;
    bus.alu_req = 1'b0;
    bus.sp_req  = 1'b0;
  endtask

  task automatic chk_wr(input string tag, input logic en, input logic [3:0] a, input logic [7:0] d);
    chk({tag, "_wen"},  32'(bus.rf_write_en),  32'(en));
    chk({tag, "_addr"}, 32'(bus.rf_addr_x),    32'(a));
    chk({tag, "_data"}, 32'(bus.rf_wr_data_x), 32'(d));
  endtask

  task automatic chk_gnt(input string tag, input logic l, input logic a, input logic s);
    chk({tag, "_ld_gnt"},  32'(bus.ld_gnt),  32'(l));
    chk({tag, "_alu_gnt"}, 32'(bus.alu_gnt), 32'(a));
    chk({tag, "_sp_gnt"},  32'(bus.sp_gnt),  32'(s));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b1;
    idle();
    bus.ld_addr = '0;  bus.ld_data = '0;
    bus.alu_addr = '0; bus.alu_data = '0;
    bus.sp_push = 1'b0;
    bus.sp_in = '0;

    // Reset: requests asserted but no grant, outputs cleared
    #1 rst_n = 1'b0;
    bus.ld_req = 1'b1; bus.alu_req = 1'b1; bus.sp_req = 1'b1;
    tick(); tick();
    chk_wr("rst", 1'b0, 4'h0, 8'h00);
    chk("rst_sp_err", 32'(bus.sp_err), 32'd0);
    chk_gnt("rst", 1'b0, 1'b0, 1'b0);
    idle();
    rst_n = 1'b1;
    tick();

    // Concurrent requests: ld, then alu, then sp push from 0x80
    bus.ld_req = 1'b1;  bus.ld_addr = 4'd3;  bus.ld_data = 8'hA5;
    bus.alu_req = 1'b1; bus.alu_addr = 4'd5; bus.alu_data = 8'h3C;
    bus.sp_req = 1'b1;  bus.sp_push = 1'b1;  bus.sp_in = 8'h80;
    #1 chk_gnt("cc1", 1'b1, 1'b0, 1'b0);
    tick(); bus.ld_req = 1'b0;
    #1 chk_wr("cc1", 1'b1, 4'd3, 8'hA5);
    chk_gnt("cc2", 1'b0, 1'b1, 1'b0);
    tick(); bus.alu_req = 1'b0;
    #1 chk_wr("cc2", 1'b1, 4'd5, 8'h3C);
    chk_gnt("cc3", 1'b0, 1'b0, 1'b1);
    tick(); bus.sp_req = 1'b0;
    #1 chk_wr("cc3", 1'b1, 4'hF, 8'h7F);
    tick(); bus.sp_in = 8'h7F;
    chk_wr("cc_idle", 1'b0, 4'hF, 8'h7F);

    // Starvation: ld held, alu held; alu wins on its 5th waiting cycle
    bus.ld_req = 1'b1;
    bus.alu_req = 1'b1; bus.alu_addr = 4'd6; bus.alu_data = 8'hC3;
    for (int i = 1; i <= 6; i++) begin
      bus.ld_addr = i[3:0];
      bus.ld_data = 8'(8'h10 + i);
      #1;
      chk($sformatf("stv%0d_ld_gnt", i),  32'(bus.ld_gnt),  32'(i != 5));
      chk($sformatf("stv%0d_alu_gnt", i), 32'(bus.alu_gnt), 32'(i == 5));
      tick();
      if (i == 5) bus.alu_req = 1'b0;
      chk_wr($sformatf("stv%0d", i), 1'b1,
             (i == 5) ? 4'd6 : i[3:0],
             (i == 5) ? 8'hC3 : 8'(8'h10 + i));
    end
    idle();
    tick();

    // Back-to-back pops from 0x10: gnt 1,0,1; writes 0x11 then 0x12
    bus.sp_in = 8'h10; bus.sp_push = 1'b0; bus.sp_req = 1'b1;
    #1 chk("b2b1_sp_gnt", 32'(bus.sp_gnt), 32'd1);
    tick();
    chk_wr("b2b1", 1'b1, 4'hF, 8'h11);
    chk("b2b2_sp_gnt", 32'(bus.sp_gnt), 32'd0);
    tick(); bus.sp_in = 8'h11;
    #1 chk("b2b3_sp_gnt", 32'(bus.sp_gnt), 32'd1);
    tick(); bus.sp_req = 1'b0;
    chk_wr("b2b3", 1'b1, 4'hF, 8'h12);
    tick(); bus.sp_in = 8'h12;
    chk("b2b_idle_wen", 32'(bus.rf_write_en), 32'd0);

    // Hazard from an ALU write to SP_ADDR while a pop waits
    bus.alu_req = 1'b1; bus.alu_addr = 4'hF; bus.alu_data = 8'h40;
    bus.sp_req = 1'b1;  bus.sp_push = 1'b0;
    #1 chk_gnt("hz1", 1'b0, 1'b1, 1'b0);
    tick(); bus.alu_req = 1'b0;
    #1 chk_wr("hz1", 1'b1, 4'hF, 8'h40);
    chk("hz2_sp_gnt", 32'(bus.sp_gnt), 32'd0);
    tick(); bus.sp_in = 8'h40;
    #1 chk("hz3_sp_gnt", 32'(bus.sp_gnt), 32'd1);
    tick(); bus.sp_req = 1'b0;
    chk_wr("hz3", 1'b1, 4'hF, 8'h41);
    tick(); bus.sp_in = 8'h41;

    // Stack limits: push at 0x00, pop at 0xFF
    bus.sp_in = 8'h00; bus.sp_push = 1'b1; bus.sp_req = 1'b1;
    #1 chk("lim_push_sp_gnt", 32'(bus.sp_gnt), 32'd1);
    tick(); bus.sp_req = 1'b0;
`ifdef STACK_LIMIT_CHECK_EN
    chk("lim_push_wen", 32'(bus.rf_write_en), 32'd0);
    chk("lim_push_err", 32'(bus.sp_err), 32'd1);
    tick();
    chk("lim_push_err_end", 32'(bus.sp_err), 32'd0);
    chk("lim_push_wen_end", 32'(bus.rf_write_en), 32'd0);
`else
    chk_wr("lim_push", 1'b1, 4'hF, 8'hFF);
    chk("lim_push_err", 32'(bus.sp_err), 32'd0);
    tick();
`endif
    bus.sp_in = 8'hFF; bus.sp_push = 1'b0; bus.sp_req = 1'b1;
    #1 chk("lim_pop_sp_gnt", 32'(bus.sp_gnt), 32'd1);
    tick(); bus.sp_req = 1'b0;
`ifdef STACK_LIMIT_CHECK_EN
    chk("lim_pop_wen", 32'(bus.rf_write_en), 32'd0);
    chk("lim_pop_err", 32'(bus.sp_err), 32'd1);
`else
    chk_wr("lim_pop", 1'b1, 4'hF, 8'h00);
    chk("lim_pop_err", 32'(bus.sp_err), 32'd0);
`endif
    tick();

    // Reset while a write is in flight
    bus.ld_req = 1'b1; bus.ld_addr = 4'd7; bus.ld_data = 8'h99;
    #1 chk("mr_ld_gnt", 32'(bus.ld_gnt), 32'd1);
    tick();
    chk_wr("mr_pre", 1'b1, 4'd7, 8'h99);
    rst_n = 1'b0;
    #1 chk_wr("mr_rst", 1'b0, 4'h0, 8'h00);
    chk("mr_rst_ld_gnt", 32'(bus.ld_gnt), 32'd0);
    idle();
    tick();
    rst_n = 1'b1;
    tick(); tick();
    chk_wr("mr_post", 1'b0, 4'h0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
